pipe_ctrl: RTL

//  Parametrised pipeline controller for the Buceros core: merges per-stage stall requests,

---
 rtl/pipe_ctrl_pkg.sv | 35 +++
 rtl/pipe_ctrl_if.sv | 39 +++
 rtl/pipe_ctrl_pulse_sync.sv | 34 +++
 rtl/pipe_ctrl.sv | 110 +++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline controller.
//  state_t   : debug FSM state (run / halted / single step)
//  stage_e   : pipeline register indices, PC is register 0
//  ZERO_REG  : hard-wired zero register, never a hazard source
//  load_use(): load-use hazard between the EX load and the ID operands
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALTED = 2'd1,
    ST_STEP   = 2'd2
  } state_t;

  typedef enum int {
    STG_PC     = 0,
    STG_IF_ID  = 1,
    STG_ID_EX  = 2,
    STG_EX_MEM = 3,
    STG_MEM_WB = 4
  } stage_e;

  localparam int              REG_AW   = 5;
  localparam logic [REG_AW-1:0] ZERO_REG = '0;

  function automatic logic load_use(input logic              ld,
                                    input logic [REG_AW-1:0] wreg,
                                    input logic [REG_AW-1:0] rs1,
                                    input logic [REG_AW-1:0] rs2,
                                    input logic              use1,
                                    input logic              use2);
    return ld && (wreg != ZERO_REG) &&
           ((use1 && (rs1 == wreg)) || (use2 && (rs2 == wreg)));
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Pipeline-control bundle between the core (master) and pipe_ctrl (slave).
//  master: drives stall/hazard/branch/debug requests, receives hold/flush.
//  slave : the controller; receives requests, drives hold/flush/status/counters.
interface pipe_ctrl_if #(
  parameter int NUM_STAGES = 5,
  parameter int CNT_W      = 32
) ();

  logic [NUM_STAGES-1:0]             stallreq_i;
  logic                              ex_load_i;
  logic [pipe_ctrl_pkg::REG_AW-1:0]  ex_wreg_addr_i;
  logic [pipe_ctrl_pkg::REG_AW-1:0]  id_rs1_addr_i;
  logic [pipe_ctrl_pkg::REG_AW-1:0]  id_rs2_addr_i;
  logic                              id_rs1_use_i;
  logic                              id_rs2_use_i;
  logic                              branch_i;
  logic                              halt_i;
  logic                              enter_i;

  logic [NUM_STAGES-1:0]             hold_o;
  logic [NUM_STAGES-1:0]             flush_o;
  logic                              branch_o;
  logic                              halted_o;
  logic [CNT_W-1:0]                  cycle_cnt_o;
  logic [CNT_W-1:0]                  stall_cnt_o;

  modport master (
    output stallreq_i, ex_load_i, ex_wreg_addr_i, id_rs1_addr_i, id_rs2_addr_i,
           id_rs1_use_i, id_rs2_use_i, branch_i, halt_i, enter_i,
    input  hold_o, flush_o, branch_o, halted_o, cycle_cnt_o, stall_cnt_o
  );

  modport slave (
    input  stallreq_i, ex_load_i, ex_wreg_addr_i, id_rs1_addr_i, id_rs2_addr_i,
           id_rs1_use_i, id_rs2_use_i, branch_i, halt_i, enter_i,
    output hold_o, flush_o, branch_o, halted_o, cycle_cnt_o, stall_cnt_o
  );

endinterface

// File: rtl/pipe_ctrl_pulse_sync.sv
// Optional 2-FF synchroniser followed by a rising-edge detector.
//  clk, rst : clock, async active-high reset
//  d        : level input (asynchronous when SYNC!=0)
//  pulse    : one-cycle pulse per rising edge of d
module pipe_ctrl_pulse_sync #(
  parameter int SYNC = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic pulse
);

  logic d_s, d_q;

  generate
    if (SYNC != 0) begin : g_sync
      logic [1:0] sync_q;
      always_ff @(posedge clk or posedge rst)
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[0], d};
      assign d_s = sync_q[1];
    end else begin : g_bypass
      assign d_s = d;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst)
    if (rst) d_q <= 1'b0;
    else     d_q <= d_s;

  assign pulse = d_s & ~d_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: merges stage stall requests, load-use detection,
// branch flush and run/halt/single-step debug into per-register hold/flush.
//  clk, rst : core clock, async active-high reset
//  bus      : pipe_ctrl_if.slave
//    in : stallreq_i, ex_load_i, ex_wreg_addr_i, id_rs{1,2}_addr_i,
//         id_rs{1,2}_use_i, branch_i, halt_i, enter_i (step button)
//    out: hold_o, flush_o, branch_o (combinational), halted_o,
//         cycle_cnt_o, stall_cnt_o (registered, wrap around)
module pipe_ctrl import pipe_ctrl_pkg::*; #(
  parameter int NUM_STAGES = 5,
  parameter int LU_IDX     = int'(STG_IF_ID),
  parameter int BR_IDX     = int'(STG_IF_ID),
  parameter int CNT_W      = 32,
  parameter int ENTER_SYNC = 1
) (
  input  logic         clk,
  input  logic         rst,
  pipe_ctrl_if.slave   bus
);

  state_t                state_q, state_d;
  logic                  lu, step_p, freeze, branch, any_req;
  logic [NUM_STAGES-1:0] ext_req, req, hold, flush;
  logic [CNT_W-1:0]      cycle_cnt_q, stall_cnt_q;
  int                    k;

  pipe_ctrl_pulse_sync #(.SYNC(ENTER_SYNC)) u_enter (
    .clk   (clk),
    .rst   (rst),
    .d     (bus.enter_i),
    .pulse (step_p)
  );

  assign lu = load_use(bus.ex_load_i, bus.ex_wreg_addr_i, bus.id_rs1_addr_i,
                       bus.id_rs2_addr_i, bus.id_rs1_use_i, bus.id_rs2_use_i);

  // STEP never freezes: the FSM leaves STEP on the cycle the PC advances.
  assign freeze = (state_q == ST_HALTED);

  always_comb begin
    ext_req         = bus.stallreq_i;
    ext_req[LU_IDX] = ext_req[LU_IDX] | lu;
    req             = ext_req;
    req[STG_PC]     = req[STG_PC] | freeze;
  end

  // k = highest requesting register: everything at or below it holds,
  // the register right after it takes a bubble.
  always_comb begin
    any_req = 1'b0;
    k       = 0;
    for (int i = 0; i < NUM_STAGES; i++)
      if (req[i]) begin
        any_req = 1'b1;
        k       = i;
      end
    hold  = '0;
    flush = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      hold[i]  = any_req && (i <= k);
      flush[i] = any_req && (i == k + 1);
    end
    // A held ID re-executes the branch later, so the jump is suppressed now.
    branch        = bus.branch_i & ~hold[BR_IDX];
    flush[BR_IDX] = flush[BR_IDX] | branch;
    if (rst) begin
      hold   = '0;
      flush  = '0;
      branch = 1'b0;
    end
  end

  assign bus.hold_o   = hold;
  assign bus.flush_o  = flush;
  assign bus.branch_o = branch;

  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:    if (bus.halt_i) state_d = ST_HALTED;
      ST_HALTED: if (!bus.halt_i)     state_d = ST_RUN;
                 else if (step_p)     state_d = ST_STEP;
      // Stay in STEP while another request still holds the PC so the step
      // is not lost; extra step pulses here are ignored.
      ST_STEP:   if (!bus.halt_i)     state_d = ST_RUN;
                 else if (!hold[STG_PC]) state_d = ST_HALTED;
      default:   state_d = ST_RUN;
    endcase
  end

  assign bus.halted_o = (state_q != ST_RUN);

  // Debug freeze is not a stall: only external and load-use requests count.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cycle_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
      if (|ext_req) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end

  assign bus.cycle_cnt_o = cycle_cnt_q;
  assign bus.stall_cnt_o = stall_cnt_q;

endmodule
